vga_timing_gen: RTL and testbench

Raster timing generator that produces the pixel coordinates, active-video qualifier and sync pulses consumed by the display pipeline. It drives `x`, `y`, `valid` and `vsync` into the display top level, and `hsync`/`vsync` to the monitor. Default timing is 1280x1024@60 Hz with a 108 MHz pixel clock. All outputs are registered, and the counters advance only on cycles where the clock enable is asserted.

---
 rtl/vga_timing_gen_if.sv | 13 +
 rtl/vga_timing_gen.sv | 82 ++++++++
 tb/tb_vga_timing_gen.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: pixel coordinates, active-video qualifier, syncs and line/frame markers.
interface vga_timing_gen_if;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        hsync;
    logic        vsync;
    logic        line_start;
    logic        frame_start;

    modport master (output x, y, valid, hsync, vsync, line_start, frame_start);
    modport slave  (input  x, y, valid, hsync, vsync, line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters stepped by ce, with
// coordinates, blanking and sync outputs registered one stage after the counters.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 48,
    parameter int unsigned H_SYNC   = 112,
    parameter int unsigned H_BP     = 248,
    parameter int unsigned V_ACTIVE = 1024,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 38,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    vga_timing_gen_if.master   vid
);

    localparam int unsigned CW      = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          h_act;
    logic          v_act;
    logic          h_sync;
    logic          v_sync;

    // Region decode of the current counter position.
    always_comb begin
        h_last = (h_cnt == H_LAST);
        v_last = (v_cnt == V_LAST);
        h_act  = (h_cnt < H_ACT);
        v_act  = (v_cnt < V_ACT);
        h_sync = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        v_sync = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    end

    // Counters and outputs advance together; held cycles suppress the start pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.valid       <= 1'b0;
            vid.hsync       <= ~SYNC_POL;
            vid.vsync       <= ~SYNC_POL;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else if (ce) begin
            h_cnt <= h_last ? '0 : h_cnt + CW'(1);
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + CW'(1);
            end
            vid.x           <= h_act ? h_cnt : '0;
            vid.y           <= v_act ? v_cnt[9:0] : '0;
            vid.valid       <= h_act && v_act;
            vid.hsync       <= h_sync ? SYNC_POL : ~SYNC_POL;
            vid.vsync       <= v_sync ? SYNC_POL : ~SYNC_POL;
            vid.line_start  <= (h_cnt == '0);
            vid.frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 1280x1024 instance plus a tiny low-active-sync instance.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        valid;
        logic        hsync;
        logic        vsync;
        logic        ls;
        logic        fs;
    } vout_t;

    typedef struct {
        bit    ce;
        vout_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic ce_a  = 1'b0;
    logic rst_b = 1'b0;
    logic ce_b  = 1'b0;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();

    vga_timing_gen dut_a (
        .clk   (clk),
        .reset (rst_a),
        .ce    (ce_a),
        .vid   (ifa.master)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .ce    (ce_b),
        .vid   (ifb.master)
    );

    vout_t out_a;
    vout_t out_b;
    assign out_a = {ifa.x, ifa.y, ifa.valid, ifa.hsync, ifa.vsync, ifa.line_start, ifa.frame_start};
    assign out_b = {ifb.x, ifb.y, ifb.valid, ifb.hsync, ifb.vsync, ifb.line_start, ifb.frame_start};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vout_t reset_out(input bit pol);
        vout_t r;
        r       = '0;
        r.hsync = ~pol;
        r.vsync = ~pol;
        return r;
    endfunction

    function automatic vout_t model_out(input int ha, input int hfp, input int hs,
                                        input int va, input int vfp, input int vs,
                                        input bit pol, input int h, input int v);
        vout_t r;
        int hs0 = ha + hfp;
        int vs0 = va + vfp;
        r = '0;
        if (h < ha) r.x = 11'(h);
        if (v < va) r.y = 10'(v);
        r.valid = (h < ha) && (v < va);
        r.hsync = (h >= hs0 && h < hs0 + hs) ? pol : ~pol;
        r.vsync = (v >= vs0 && v < vs0 + vs) ? pol : ~pol;
        r.ls    = (h == 0);
        r.fs    = (h == 0) && (v == 0);
        return r;
    endfunction

    function automatic vout_t mk(input int x, input int y, input bit v, input bit hs,
                                 input bit vs, input bit ls, input bit fs);
        vout_t r;
        r = {11'(x), 10'(y), v, hs, vs, ls, fs};
        return r;
    endfunction

    // Scoreboard: expected outputs pushed at each clock edge, popped mid-cycle.
    int    mh_a = 0, mv_a = 0, mh_b = 0, mv_b = 0;
    vout_t last_a, last_b;
    vout_t q_a[$];
    vout_t q_b[$];

    initial begin : model_a
        vout_t e;
        forever begin
            @(posedge clk);
            if (!rst_a) begin
                mh_a = 0; mv_a = 0; e = reset_out(1'b1);
            end else if (ce_a) begin
                e = model_out(1280, 48, 112, 1024, 1, 3, 1'b1, mh_a, mv_a);
                mh_a++;
                if (mh_a == 1688) begin
                    mh_a = 0; mv_a++;
                    if (mv_a == 1066) mv_a = 0;
                end
            end else begin
                e = last_a; e.ls = 1'b0; e.fs = 1'b0;
            end
            last_a = e;
            q_a.push_back(e);
        end
    end

    initial begin : model_b
        vout_t e;
        forever begin
            @(posedge clk);
            if (!rst_b) begin
                mh_b = 0; mv_b = 0; e = reset_out(1'b0);
            end else if (ce_b) begin
                e = model_out(4, 1, 2, 3, 1, 1, 1'b0, mh_b, mv_b);
                mh_b++;
                if (mh_b == 8) begin
                    mh_b = 0; mv_b++;
                    if (mv_b == 6) mv_b = 0;
                end
            end else begin
                e = last_b; e.ls = 1'b0; e.fs = 1'b0;
            end
            last_b = e;
            q_b.push_back(e);
        end
    end

    initial begin : chk_a
        vout_t e;
        forever begin
            @(negedge clk);
            e = (q_a.size() != 0) ? q_a.pop_front() : reset_out(1'b1);
            if (!rst_a) e = reset_out(1'b1);
            check("sb_a", 64'(out_a), 64'(e));
        end
    end

    initial begin : chk_b
        vout_t e;
        forever begin
            @(negedge clk);
            e = (q_b.size() != 0) ? q_b.pop_front() : reset_out(1'b0);
            if (!rst_b) e = reset_out(1'b0);
            check("sb_b", 64'(out_b), 64'(e));
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    vec_t  tv[13];
    vout_t prev, p;
    int    vcnt, xerr, hs_first, hs_len, next_ls;
    int    nhigh, ls1, ls2, hold_err, dup_err, step_err;
    int    fs_next, vs_cnt, vs_first, hs_cnt, last_x, last_y, ynz, ls_cnt;
    bit    c;

    initial begin
        tv[0]  = '{1'b1, mk(0, 0, 1, 1, 1, 1, 1)};
        tv[1]  = '{1'b0, mk(0, 0, 1, 1, 1, 0, 0)};
        tv[2]  = '{1'b1, mk(1, 0, 1, 1, 1, 0, 0)};
        tv[3]  = '{1'b1, mk(2, 0, 1, 1, 1, 0, 0)};
        tv[4]  = '{1'b1, mk(3, 0, 1, 1, 1, 0, 0)};
        tv[5]  = '{1'b1, mk(0, 0, 0, 1, 1, 0, 0)};
        tv[6]  = '{1'b1, mk(0, 0, 0, 0, 1, 0, 0)};
        tv[7]  = '{1'b0, mk(0, 0, 0, 0, 1, 0, 0)};
        tv[8]  = '{1'b1, mk(0, 0, 0, 0, 1, 0, 0)};
        tv[9]  = '{1'b1, mk(0, 0, 0, 1, 1, 0, 0)};
        tv[10] = '{1'b1, mk(0, 1, 1, 1, 1, 1, 0)};
        tv[11] = '{1'b1, mk(1, 1, 1, 1, 1, 0, 0)};
        tv[12] = '{1'b0, mk(1, 1, 1, 1, 1, 0, 0)};

        // Reset held with ce high
        rst_a = 1'b0; ce_a = 1'b1; rst_b = 1'b0; ce_b = 1'b0;
        repeat (10) tick();
        check("rst_valid", 64'(out_a.valid), 64'(0));
        check("rst_x",     64'(out_a.x),     64'(0));
        check("rst_y",     64'(out_a.y),     64'(0));
        check("rst_hsync", 64'(out_a.hsync), 64'(0));
        check("rst_vsync", 64'(out_a.vsync), 64'(0));
        rst_a = 1'b1;
        tick();
        check("first_fs",    64'(out_a.fs),    64'(1));
        check("first_ls",    64'(out_a.ls),    64'(1));
        check("first_valid", 64'(out_a.valid), 64'(1));
        check("first_xy",    64'({out_a.x, out_a.y}), 64'(0));

        // One full line, then on to line 1 pixel 700
        vcnt = 1; xerr = 0; hs_first = -1; hs_len = 0; next_ls = -1;
        for (int k = 1; k <= 2388; k++) begin
            tick();
            if (k < 1688) begin
                if (out_a.valid) vcnt++;
                if (k < 1280 && out_a.x != 11'(k)) xerr++;
                if (out_a.hsync) begin
                    if (hs_first < 0) hs_first = k;
                    hs_len++;
                end
            end
            if (out_a.ls && next_ls < 0) next_ls = k;
        end
        check("line_valid_len", 64'(vcnt),     64'(1280));
        check("line_x_seq",     64'(xerr),     64'(0));
        check("hsync_start",    64'(hs_first), 64'(1328));
        check("hsync_len",      64'(hs_len),   64'(112));
        check("line_period",    64'(next_ls),  64'(1688));
        check("pos_x700",       64'(out_a.x),  64'(700));
        check("pos_y1",         64'(out_a.y),  64'(1));

        // Asynchronous reset mid-line, checked before any clock edge
        rst_a = 1'b0;
        #1;
        check("async_valid", 64'(out_a.valid), 64'(0));
        check("async_x",     64'(out_a.x),     64'(0));
        check("async_y",     64'(out_a.y),     64'(0));
        tick(); tick();
        rst_a = 1'b1; ce_a = 1'b1;
        tick();
        check("restart_fs",  64'(out_a.fs),    64'(1));
        check("restart_xyv", 64'({out_a.x, out_a.y, out_a.valid}), 64'(1));

        // ce pattern 1,0,0,1
        nhigh = 0; ls1 = -1; ls2 = -1; hold_err = 0; dup_err = 0; step_err = 0;
        prev = out_a;
        for (int i = 0; i < 8000 && ls2 < 0; i++) begin
            c = (i % 4 == 0) || (i % 4 == 3);
            ce_a = c;
            tick();
            if (c) begin
                nhigh++;
                if (prev.valid && out_a.valid && out_a.x != prev.x + 11'd1) step_err++;
                if (out_a.ls) begin
                    if (ls1 < 0) ls1 = nhigh;
                    else ls2 = nhigh;
                end
            end else begin
                if (out_a.ls || out_a.fs) dup_err++;
                p = prev; p.ls = 1'b0; p.fs = 1'b0;
                if (out_a !== p) hold_err++;
            end
            prev = out_a;
        end
        check("ce_line1",    64'(ls1),       64'(1688));
        check("ce_line2",    64'(ls2 - ls1), 64'(1688));
        check("ce_step",     64'(step_err),  64'(0));
        check("ce_dup",      64'(dup_err),   64'(0));
        check("ce_hold",     64'(hold_err),  64'(0));
        ce_a = 1'b0;

        // Small instance: vector table
        rst_b = 1'b1;
        tick();
        check("b_rst", 64'(out_b), 64'(mk(0, 0, 0, 1, 1, 0, 0)));
        for (int i = 0; i < 13; i++) begin
            ce_b = tv[i].ce;
            tick();
            check($sformatf("vec%0d", i), 64'(out_b), 64'(tv[i].exp));
        end

        // Small instance: one full frame from a fresh reset
        rst_b = 1'b0; ce_b = 1'b1;
        tick();
        rst_b = 1'b1;
        tick();
        check("b_fs0", 64'(out_b.fs), 64'(1));
        fs_next = -1; vs_cnt = 0; vs_first = -1; hs_cnt = 0; hs_first = -1;
        vcnt = 0; last_x = -1; last_y = -1; ynz = 0; ls_cnt = 0;
        for (int k = 0; k <= 48; k++) begin
            if (k > 0 && out_b.fs && fs_next < 0) fs_next = k;
            if (k < 48) begin
                if (!out_b.vsync) begin
                    if (vs_first < 0) vs_first = k;
                    vs_cnt++;
                end
                if (!out_b.hsync) begin
                    if (hs_first < 0) hs_first = k;
                    hs_cnt++;
                end
                if (out_b.valid) begin
                    vcnt++; last_x = int'(out_b.x); last_y = int'(out_b.y);
                end
                if (k >= 24 && out_b.y != 10'd0) ynz++;
                if (out_b.ls) ls_cnt++;
                tick();
            end
        end
        check("b_frame_period", 64'(fs_next),  64'(48));
        check("b_vsync_start",  64'(vs_first), 64'(32));
        check("b_vsync_len",    64'(vs_cnt),   64'(8));
        check("b_hsync_start",  64'(hs_first), 64'(5));
        check("b_hsync_len",    64'(hs_cnt),   64'(12));
        check("b_valid_cnt",    64'(vcnt),     64'(12));
        check("b_last_pix",     64'({last_x[7:0], last_y[7:0]}), 64'(16'h0302));
        check("b_y_blank",      64'(ynz),      64'(0));
        check("b_line_cnt",     64'(ls_cnt),   64'(6));

        // Small instance: mid-frame asynchronous reset at (2, 1)
        repeat (10) tick();
        check("b_pos", 64'({out_b.x, out_b.y, out_b.valid}), 64'({11'd2, 10'd1, 1'b1}));
        rst_b = 1'b0;
        #1;
        check("b_async", 64'(out_b), 64'(mk(0, 0, 0, 1, 1, 0, 0)));
        tick();
        rst_b = 1'b1;
        tick();
        check("b_restart", 64'(out_b), 64'(mk(0, 0, 1, 1, 1, 1, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
